// File: rtl/blink_seq_pkg.sv
// blink_seq_pkg: shared types and defaults for the LED pattern sequencer.
//   state_e  - sequencer FSM states
//   cfg_t    - one pattern configuration at default widths
//   PLEN_DEF / RW_DEF / LW_DEF - default pattern length, repeat width, index width
package blink_seq_pkg;

  localparam int PLEN_DEF = 8;
  localparam int RW_DEF   = 4;
  localparam int LW_DEF   = $clog2(PLEN_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic [PLEN_DEF-1:0] pattern;
    logic [LW_DEF-1:0]   len;
    logic [RW_DEF-1:0]   reps;
    logic                gate;
  } cfg_t;

endpackage

// File: rtl/blink_seq_ctr.sv
// blink_seq_ctr: step index and repeat counter for blink_seq.
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   tick            - advance one step (already qualified by the FSM)
//   load            - start a new pattern: step := 0, repeats := reps
//   clear           - return to idle values; wins over load and tick
//   len, reps       - last step index and extra repetitions
//   step            - current step index, never exceeds len
//   last            - on the final step of the final repetition
module blink_seq_ctr
  import blink_seq_pkg::*;
#(
  parameter  int PLEN = PLEN_DEF,
  parameter  int RW   = RW_DEF,
  localparam int LW   = $clog2(PLEN)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          load,
  input  logic          clear,
  input  logic [LW-1:0] len,
  input  logic [RW-1:0] reps,
  output logic [LW-1:0] step,
  output logic          last
);

  logic [LW-1:0] r_step;
  logic [RW-1:0] r_reps_left;
  logic          w_at_len;

  assign w_at_len = (r_step == len);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_step      <= '0;
      r_reps_left <= '0;
    end else if (clear) begin
      r_step      <= '0;
      r_reps_left <= '0;
    end else if (load) begin
      r_step      <= '0;
      r_reps_left <= reps;
    end else if (tick) begin
      if (!w_at_len) begin
        r_step <= r_step + LW'(1);
      end else if (r_reps_left != '0) begin
        r_step      <= '0;
        r_reps_left <= r_reps_left - RW'(1);
      end
      // at len with no repeats left the FSM leaves RUN and clears us
    end
  end

  assign step = r_step;
  assign last = w_at_len && (r_reps_left == '0);

endmodule

// File: rtl/blink_seq.sv
// blink_seq: plays a programmable on/off pattern on an LED, one bit per
// blinker tick, with optional gating by the blinker's own led level.
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   tick         - step strobe from the blinker wrap flag
//   led_in       - blinker led level, ANDed in when gate is set
//   cfg_valid    - config offered; cfg_ready - config can be taken
//   cfg_pattern  - bit i drives the LED at step i
//   cfg_len      - steps minus one; cfg_reps - extra repetitions
//   cfg_gate     - AND pattern with led_in
//   abort        - synchronous stop, no done pulse
//   led_out      - sequenced LED; busy - playing; done - completion pulse
//   step         - current step index
// Optional: define BLINK_SEQ_ASSERT_EN to compile in embedded SVA checks.
//
// state | meaning
// IDLE  | waiting for config, cfg_ready high
// RUN   | playing pattern, one step per tick
// DONE  | one-cycle completion pulse, then IDLE
module blink_seq
  import blink_seq_pkg::*;
#(
  parameter  int PLEN = PLEN_DEF,
  parameter  int RW   = RW_DEF,
  localparam int LW   = $clog2(PLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tick,
  input  logic            led_in,
  input  logic            cfg_valid,
  output logic            cfg_ready,
  input  logic [PLEN-1:0] cfg_pattern,
  input  logic [LW-1:0]   cfg_len,
  input  logic [RW-1:0]   cfg_reps,
  input  logic            cfg_gate,
  input  logic            abort,
  output logic            led_out,
  output logic            busy,
  output logic            done,
  output logic [LW-1:0]   step
);

  state_e          r_state;
  state_e          w_state_nxt;
  logic [PLEN-1:0] r_pat;
  logic [LW-1:0]   r_len;
  logic            r_gate;

  logic            w_accept;
  logic            w_adv;
  logic            w_clr;
  logic            w_last;
  logic [LW-1:0]   w_step;

  // abort wins over a pending config in IDLE
  assign w_accept = (r_state == IDLE) && cfg_valid && !abort;
  // ticks only count while running, and abort drops a coincident tick
  assign w_adv    = (r_state == RUN) && tick && !abort;
  // counter returns to 0 on leaving RUN so step reads 0 in DONE and IDLE
  assign w_clr    = (r_state == RUN) && (abort || (tick && w_last));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_pat   <= '0;
      r_len   <= '0;
      r_gate  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_pat  <= cfg_pattern;
        r_len  <= cfg_len;
        r_gate <= cfg_gate;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    cfg_ready   = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    led_out     = 1'b0;
    case (r_state)
      IDLE: begin
        cfg_ready = 1'b1;
        if (w_accept) w_state_nxt = RUN;
      end
      RUN: begin
        busy    = 1'b1;
        led_out = r_pat[w_step] & (led_in | ~r_gate);
        if (abort)               w_state_nxt = IDLE;
        else if (tick && w_last) w_state_nxt = DONE;
      end
      DONE: begin
        done        = !abort;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  blink_seq_ctr #(
    .PLEN (PLEN),
    .RW   (RW)
  ) u_ctr (
    .clk   (clk),
    .rst   (rst),
    .tick  (w_adv),
    .load  (w_accept),
    .clear (w_clr),
    .len   (r_len),
    .reps  (cfg_reps),
    .step  (w_step),
    .last  (w_last)
  );

  assign step = w_step;

`ifdef BLINK_SEQ_ASSERT_EN
  a_ready_not_busy: assert property (@(posedge clk) disable iff (rst) cfg_ready |-> !busy);
  a_idle_led_off:   assert property (@(posedge clk) disable iff (rst) !busy |-> !led_out);
  a_done_ready:     assert property (@(posedge clk) disable iff (rst) done |=> cfg_ready);
  a_step_le_len:    assert property (@(posedge clk) disable iff (rst) w_step <= r_len);
  // with ticks arriving fairly, a run ends either in done or in an abort
  a_live_done:      assert property (@(posedge clk) disable iff (rst)
                                     busy |-> s_eventually (done || abort));
`else
  // no embedded properties in this build
`endif

endmodule
